// File: rtl/seg_display_driver_if.sv
// Load handshake and display outputs shared by the 7-segment driver and its host.
interface seg_display_driver_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 4
);
    logic [DATA_WIDTH-1:0]   value;
    logic                    load;
    logic                    mode_dec;
    logic                    blank_lz;
    logic                    busy;
    logic                    done;
    logic                    overflow;
    logic [7*NUM_DIGITS-1:0] seg_out;

    modport master (
        output value, load, mode_dec, blank_lz,
        input  busy, done, overflow, seg_out
    );

    modport slave (
        input  value, load, mode_dec, blank_lz,
        output busy, done, overflow, seg_out
    );
endinterface

// File: rtl/seg_display_driver.sv
// Multi-digit active-low 7-segment driver: hex nibble split or sequential
// double-dabble decimal, with leading-zero blanking and overflow dashes.
module seg_display_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seg_display_driver_if.slave  bus
);
    localparam int BCD_DIGITS = (3 * DATA_WIDTH + 9) / 10;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DIG_W      = 4 * NUM_DIGITS;
    localparam int SEG_W      = 7 * NUM_DIGITS;
    localparam int HEX_PAD_W  = (DATA_WIDTH > DIG_W) ? DATA_WIDTH : DIG_W;
    localparam int BCD_PAD_W  = (BCD_W > DIG_W) ? BCD_W : DIG_W;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam int SHIFT_W    = BCD_W + DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CONV, ENC} state_t;

    state_t                 state;
    state_t                 state_next;

    logic [DATA_WIDTH-1:0]  shift_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   mode_q;
    logic                   blank_q;
    logic                   done_q;
    logic                   ovf_q;
    logic [SEG_W-1:0]       seg_q;

    logic [BCD_W-1:0]       bcd_adj;
    logic [SHIFT_W-1:0]     dabble_shifted;
    logic [HEX_PAD_W-1:0]   hex_pad;
    logic [BCD_PAD_W-1:0]   bcd_pad;
    logic [DIG_W-1:0]       digits;
    logic                   ovf_next;
    logic [SEG_W-1:0]       seg_next;
    logic                   leading;
    logic [3:0]             digit;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.seg_out  = seg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.load) state_next = CONV;
            CONV: if (!mode_q || cnt_q == CNT_W'(DATA_WIDTH - 1)) state_next = ENC;
            ENC:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: adjust every BCD nibble, then shift {bcd, value} left.
    assign bcd_adj        = dabble_adjust(bcd_q);
    assign dabble_shifted = {bcd_adj, shift_q} << 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            blank_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            seg_q   <= '1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shift_q <= bus.value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        mode_q  <= bus.mode_dec;
                        blank_q <= bus.blank_lz;
                    end
                end
                CONV: begin
                    if (mode_q) begin
                        bcd_q   <= dabble_shifted[SHIFT_W-1:DATA_WIDTH];
                        shift_q <= dabble_shifted[DATA_WIDTH-1:0];
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ENC: begin
                    seg_q  <= seg_next;
                    ovf_q  <= ovf_next;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Encoder: scan from the most significant digit so blanking stops at the first nonzero.
    always_comb begin
        hex_pad  = HEX_PAD_W'(shift_q);
        bcd_pad  = BCD_PAD_W'(bcd_q);
        digits   = mode_q ? bcd_pad[DIG_W-1:0] : hex_pad[DIG_W-1:0];
        ovf_next = mode_q ? ((bcd_pad >> DIG_W) != '0) : ((hex_pad >> DIG_W) != '0);
        seg_next = '1;
        leading  = 1'b1;
        digit    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            digit = digits[4*i +: 4];
            if (digit != 4'h0)
                leading = 1'b0;
            if (ovf_next)
                seg_next[7*i +: 7] = ~7'h40;
            else if (blank_q && leading && i != 0)
                seg_next[7*i +: 7] = 7'h7F;
            else
                seg_next[7*i +: 7] = ~glyph(digit);
        end
    end
endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver at DATA_WIDTH=16, NUM_DIGITS=4.
module tb_seg_display_driver;
    localparam int DW = 16;
    localparam int ND = 4;

    typedef struct packed {
        logic [7*ND-1:0] seg;
        logic            ovf;
        logic [7:0]      lat;
    } exp_t;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    seg_display_driver_if #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) bus ();

    seg_display_driver #(.DATA_WIDTH(DW), .NUM_DIGITS(ND)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [DW-1:0] v, input logic dec, input logic blz);
        exp_t        e;
        int unsigned rem;
        int unsigned d [ND];
        int          top;
        rem = v;
        top = -1;
        e   = '0;
        for (int i = 0; i < ND; i++) begin
            d[i] = dec ? rem % 10 : rem % 16;
            rem  = dec ? rem / 10 : rem / 16;
        end
        e.ovf = (rem != 0);
        for (int i = 0; i < ND; i++)
            if (d[i] != 0) top = i;
        for (int i = 0; i < ND; i++) begin
            if (e.ovf)
                e.seg[7*i +: 7] = 7'h3F;
            else if (blz && i > top && i > 0)
                e.seg[7*i +: 7] = 7'h7F;
            else
                e.seg[7*i +: 7] = ~GLYPH[d[i]];
        end
        e.lat = dec ? 8'(DW + 1) : 8'd2;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one load for a single edge (the accepting edge) and record the expectation.
    task automatic start(input logic [DW-1:0] v, input logic dec, input logic blz);
        bus.value    = v;
        bus.mode_dec = dec;
        bus.blank_lz = blz;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        sb.push_back(model(v, dec, blz));
    endtask

    // Count edges until done; flags any seg_out/overflow change seen before done.
    task automatic collect(output int lat, output logic [7*ND-1:0] seg, output logic ovf,
                           output bit timeout, output bit early);
        logic [7*ND-1:0] seg_before;
        logic            ovf_before;
        seg_before = bus.seg_out;
        ovf_before = bus.overflow;
        lat     = 0;
        timeout = 1'b1;
        early   = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat     = k;
                timeout = 1'b0;
                break;
            end
            if (bus.seg_out !== seg_before || bus.overflow !== ovf_before)
                early = 1'b1;
        end
        seg = bus.seg_out;
        ovf = bus.overflow;
    endtask

    task automatic test_reset();
        logic [7*ND+2:0] obs;
        reset_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.value    = DW'($urandom);
            bus.load     = 1'($urandom);
            bus.mode_dec = 1'($urandom);
            bus.blank_lz = 1'($urandom);
            tick();
            obs = {bus.seg_out, bus.busy, bus.done, bus.overflow};
            n_checks++;
            if (obs !== {{7*ND{1'b1}}, 3'b000})
                $display("FAIL reset_hold[%0d]: got %h want %h", c, obs, {{7*ND{1'b1}}, 3'b000});
            else
                n_pass++;
        end
        bus.load = 1'b0;
        reset_n  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.value = DW'($urandom);
            tick();
            obs = {bus.seg_out, bus.busy, bus.done, bus.overflow};
            n_checks++;
            if (obs !== {{7*ND{1'b1}}, 3'b000})
                $display("FAIL reset_release[%0d]: got %h want %h", c, obs, {{7*ND{1'b1}}, 3'b000});
            else
                n_pass++;
        end
    endtask

    task automatic test_hex();
        logic [DW-1:0]   vals [3] = '{16'h03A7, 16'h03A7, 16'h00F0};
        logic            blzs [3] = '{1'b0, 1'b1, 1'b1};
        int              lat;
        logic [7*ND-1:0] seg;
        logic            ovf;
        bit              tmo, early;
        exp_t            e;
        for (int t = 0; t < 3; t++) begin
            start(vals[t], 1'b0, blzs[t]);
            collect(lat, seg, ovf, tmo, early);
            e = sb.pop_front();
            n_checks++;
            if (tmo || lat != int'(e.lat)) $display("FAIL hex_latency[%0d]: got %0d want %0d", t, lat, e.lat);
            else n_pass++;
            n_checks++;
            if (seg !== e.seg) $display("FAIL hex_seg[%0d]: got %h want %h", t, seg, e.seg);
            else n_pass++;
            n_checks++;
            if (ovf !== e.ovf) $display("FAIL hex_ovf[%0d]: got %b want %b", t, ovf, e.ovf);
            else n_pass++;
            tick();
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL hex_done_pulse[%0d]: got done=%b busy=%b want 0 0", t, bus.done, bus.busy);
            else n_pass++;
        end
    endtask

    task automatic test_decimal();
        logic [DW-1:0]   vals [4] = '{16'd1234, 16'd0, 16'd9, 16'd60009};
        logic            blzs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int              lat;
        logic [7*ND-1:0] seg;
        logic            ovf;
        bit              tmo, early;
        exp_t            e;
        for (int t = 0; t < 4; t++) begin
            start(vals[t], 1'b1, blzs[t]);
            collect(lat, seg, ovf, tmo, early);
            e = sb.pop_front();
            n_checks++;
            if (tmo || lat != int'(e.lat)) $display("FAIL dec_latency[%0d]: got %0d want %0d", t, lat, e.lat);
            else n_pass++;
            n_checks++;
            if (early !== 1'b0) $display("FAIL dec_hold[%0d]: got early change=%b want 0", t, early);
            else n_pass++;
            n_checks++;
            if (seg !== e.seg) $display("FAIL dec_seg[%0d]: got %h want %h", t, seg, e.seg);
            else n_pass++;
            n_checks++;
            if (ovf !== e.ovf) $display("FAIL dec_ovf[%0d]: got %b want %b", t, ovf, e.ovf);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0]   vals [3] = '{16'd65535, 16'd42, 16'd42};
        logic            blzs [3] = '{1'b1, 1'b0, 1'b1};
        int              lat;
        logic [7*ND-1:0] seg;
        logic            ovf;
        bit              tmo, early;
        exp_t            e;
        for (int t = 0; t < 3; t++) begin
            start(vals[t], 1'b1, blzs[t]);
            collect(lat, seg, ovf, tmo, early);
            e = sb.pop_front();
            n_checks++;
            if (tmo || seg !== e.seg) $display("FAIL ovf_seg[%0d]: got %h want %h", t, seg, e.seg);
            else n_pass++;
            n_checks++;
            if (ovf !== e.ovf) $display("FAIL ovf_flag[%0d]: got %b want %b", t, ovf, e.ovf);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   dones;
        bit   seen;
        exp_t e;
        start(16'd1234, 1'b1, 1'b0);
        dones = 0;
        lat   = 0;
        seen  = 1'b0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            bus.load  = (k == 3 || k == 10);
            bus.value = bus.load ? 16'd9999 : 16'd0;
            tick();
            bus.load = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                lat  = k;
                seen = 1'b1;
            end
        end
        e = sb.pop_front();
        n_checks++;
        if (!seen || lat != int'(e.lat)) $display("FAIL busy_ignore_latency: got %0d want %0d", lat, e.lat);
        else n_pass++;
        n_checks++;
        if (bus.seg_out !== e.seg) $display("FAIL busy_ignore_seg: got %h want %h", bus.seg_out, e.seg);
        else n_pass++;
        // Load presented during the done cycle must be accepted.
        start(16'd42, 1'b1, 1'b1);
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", bus.busy);
        else n_pass++;
        begin
            logic [7*ND-1:0] seg;
            logic            ovf;
            bit              tmo, early;
            collect(lat, seg, ovf, tmo, early);
            e = sb.pop_front();
            n_checks++;
            if (tmo || lat != int'(e.lat) || seg !== e.seg)
                $display("FAIL b2b_result: got lat=%0d seg=%h want lat=%0d seg=%h", lat, seg, e.lat, e.seg);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_abort();
        logic [7*ND+2:0] obs;
        int              lat;
        logic [7*ND-1:0] seg;
        logic            ovf;
        bit              tmo, early, stray;
        exp_t            e;
        start(16'd500, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) tick();
        reset_n = 1'b0;
        #1;
        obs = {bus.seg_out, bus.busy, bus.done, bus.overflow};
        n_checks++;
        if (obs !== {{7*ND{1'b1}}, 3'b000})
            $display("FAIL abort_reset: got %h want %h", obs, {{7*ND{1'b1}}, 3'b000});
        else n_pass++;
        void'(sb.pop_back());
        stray = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray) $display("FAIL abort_no_done: got stray done/busy=1 want 0");
        else n_pass++;
        start(16'd7, 1'b1, 1'b1);
        collect(lat, seg, ovf, tmo, early);
        e = sb.pop_front();
        n_checks++;
        if (tmo || lat != int'(e.lat) || seg !== e.seg || ovf !== e.ovf)
            $display("FAIL abort_recover: got lat=%0d seg=%h ovf=%b want lat=%0d seg=%h ovf=%b",
                     lat, seg, ovf, e.lat, e.seg, e.ovf);
        else n_pass++;
        tick();
    endtask

    initial begin
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.mode_dec = 1'b0;
        bus.blank_lz = 1'b0;
        test_reset();
        test_hex();
        test_decimal();
        test_overflow();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
- Parametrised multi-digit 7-segment display driver; successor to the single-nibble hex decoder.
- Captures a DATA_WIDTH-bit value on a load handshake.
- Renders the value in hex or in unsigned decimal across NUM_DIGITS active-low digits:
  - hex: direct nibble split;
  - decimal: sequential double-dabble, one shift per clock.
- Provides leading-zero blanking and overflow indication. Sits between the CPU register/ALU debug taps and the board HEX displays.

Parameters:
- DATA_WIDTH, 16: input value width; legal range 4..64.
- NUM_DIGITS, 4: number of 7-segment digits driven; legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- value  input  DATA_WIDTH  unsigned value to display
- load  input  1  request to capture value; honoured only when busy=0
- mode_dec  input  1  1 = decimal, 0 = hex; sampled with load
- blank_lz  input  1  1 = blank leading zeros; sampled with load
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the display outputs update
- overflow  output  1  registered; value did not fit in NUM_DIGITS digits
- seg_out  output  7*NUM_DIGITS  digit i occupies bits [7i+6:7i]; digit 0 is least significant; per digit bit order {g,f,e,d,c,b,a}, active low

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, busy=0, done=0, overflow=0;
  - seg_out all ones (all digits dark);
  - internal shift/BCD/counter registers cleared.
- FSM states IDLE, CONV, ENC. busy = (state != IDLE).
- Load acceptance:
  - IDLE and load=1 at a rising edge: capture value, mode_dec and blank_lz; clear the BCD register and the counter; go to CONV.
  - load while busy is ignored. There is no queueing and no error flag.
- Hex mode:
  - CONV lasts exactly 1 cycle; digit i = value[4i+3:4i], zero-extended where DATA_WIDTH < 4*NUM_DIGITS.
  - overflow = any captured bit at index >= 4*NUM_DIGITS is nonzero.
- Decimal mode:
  - CONV lasts exactly DATA_WIDTH cycles. Each cycle, every BCD nibble >= 5 gets +3, then {bcd, shift} shifts left by 1 with the value MSB first.
  - Internal BCD width is 4*BCD_DIGITS, BCD_DIGITS = (3*DATA_WIDTH+9)/10 (exact for DATA_WIDTH <= 64).
  - overflow = any BCD digit at index >= NUM_DIGITS is nonzero.
- ENC (1 cycle), then IDLE. On the edge leaving ENC, in the same edge:
  - seg_out and overflow are registered;
  - done goes high for exactly the following cycle.
- Latency from the accepting edge to seg_out/done update: hex 2 edges; decimal DATA_WIDTH+1 edges.
- seg_out holds its value between conversions and changes only on the ENC->IDLE edge (no partial updates visible).
- Glyphs, active-high before inversion:
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F;
  - A 77, b 7C, C 39, d 5E, E 79, F 71;
  - blank 00, dash 40.
  - In decimal mode, 9 uses 6F (segment d lit).
- Leading-zero blanking (blank_lz=1): every zero digit above the highest nonzero digit is blank. Digit 0 is never blanked, so value 0 shows a single "0".
- Overflow: all NUM_DIGITS digits show dash (seg 7'h3F each after inversion); blanking does not apply.
- Reset during CONV/ENC: conversion is aborted, reset values apply immediately, and done never pulses for the aborted request.
- load asserted on the same edge that returns to IDLE is not accepted. Acceptance needs state=IDLE at the sampling edge, so the earliest back-to-back load is the cycle done is high.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> seg_out all 1s, busy=0, done=0, overflow=0. Release -> values hold until the first load.
- Hex, DATA_WIDTH=16, NUM_DIGITS=4: value=16'h03A7, mode_dec=0, blank_lz=0 -> after 2 edges done pulses once. Digits 3..0 = ~3F,~4F,~77,~07. With blank_lz=1, digit 3 = 7'h7F.
- Decimal: value=1234, mode_dec=1, blank_lz=0 -> done exactly 17 edges after acceptance. Digits = 1,2,3,4, overflow=0. Value=0 with blank_lz=1 -> digits 3..1 = 7'h7F, digit 0 = ~3F.
- Overflow: value=65535, mode_dec=1, NUM_DIGITS=4 -> overflow=1, all digits 7'h3F. Next load of 42 -> overflow=0, digits show "0042", or "  42" with blanking.
- Busy handling: load 1234, then pulse load with 9999 at edges 3 and 10 -> single done, display 1234. Load on the done cycle is accepted.
- Abort: load 500, drop reset_n at edge 8 -> immediate reset values, no done pulse. After release, a new load of 7 displays correctly.
